keypad_scanner: RTL and testbench

Reader side of the 4x4 keypad matrix interface. It drives one keypadRow line low at a time, samples keypadCol, and debounces over whole scan frames. It emits a one-cycle key event plus the pattern_idx / draw controls that feed the pattern loader and conway_fsm. It runs on the system clock, with an internal scan divider in place of a separate clk_div instance.

---
 rtl/keypad_scanner.sv | 201 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : 4x4 keypad matrix reader with row scan and frame-level debounce.
// Revision : 1.0  initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV = 250000,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keypadCol,
    output logic [3:0] keypadRow,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] pattern_idx,
    output logic       draw
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W:0]   DEB_TGT  = (CNT_W + 1)'(DEBOUNCE);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_HELD         = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_row;
    logic [3:0]       r_col_s1, r_col_s2;
    logic [1:0]       r_hits;
    logic [3:0]       r_first;
    state_t           r_state, w_state_nxt;
    logic [3:0]       r_cand, w_cand_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic             w_tick, w_eval;
    logic [2:0]       w_row_cnt, w_sum;
    logic [1:0]       w_row_col, w_sat;
    logic [3:0]       w_first;
    logic             w_empty, w_single;
    logic [CNT_W:0]   w_cnt_inc;
    logic             w_accept, w_release;

    assign w_tick = (r_div == DIV_LAST);
    assign w_eval = w_tick && (r_row == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div     <= '0;
            r_row     <= 2'd0;
            keypadRow <= 4'b1110;
            r_col_s1  <= 4'hF;
            r_col_s2  <= 4'hF;
        end else begin
            r_div    <= w_tick ? '0 : r_div + 1'b1;
            r_col_s1 <= keypadCol;
            r_col_s2 <= r_col_s1;
            if (w_tick) begin
                r_row     <= r_row + 2'd1;
                keypadRow <= {keypadRow[2:0], keypadRow[3]};
            end
        end
    end

    // Lowest-numbered low column wins as the candidate code for this row.
    always_comb begin
        w_row_cnt = 3'd0;
        w_row_col = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!r_col_s2[c]) begin
                w_row_cnt = w_row_cnt + 3'd1;
                w_row_col = 2'(c);
            end
        end
    end

    assign w_sum    = {1'b0, r_hits} + w_row_cnt;
    assign w_sat    = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    assign w_first  = (r_hits == 2'd0) ? {r_row, w_row_col} : r_first;
    assign w_empty  = (w_sat == 2'd0);
    assign w_single = (w_sat == 2'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hits  <= 2'd0;
            r_first <= 4'd0;
        end else if (w_tick) begin
            if (r_row == 2'd3) begin
                r_hits  <= 2'd0;
                r_first <= 4'd0;
            end else begin
                r_hits  <= w_sat;
                r_first <= w_first;
            end
        end
    end

    assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        if (w_eval) begin
            case (r_state)
                S_IDLE: begin
                    if (w_single) begin
                        w_cand_nxt = w_first;
                        w_cnt_nxt  = CNT_W'(1);
                        if (DEBOUNCE == 1) begin
                            w_accept    = 1'b1;
                            w_state_nxt = S_HELD;
                        end else begin
                            w_state_nxt = S_PRESS_WAIT;
                        end
                    end
                end
                S_PRESS_WAIT: begin
                    if (w_single && (w_first == r_cand)) begin
                        if (w_cnt_inc >= DEB_TGT) begin
                            w_accept    = 1'b1;
                            w_state_nxt = S_HELD;
                        end else begin
                            w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
                        end
                    end else if (w_single) begin
                        w_cand_nxt = w_first;
                        w_cnt_nxt  = CNT_W'(1);
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (w_empty) begin
                        if (DEBOUNCE == 1) begin
                            w_release   = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_cnt_nxt   = CNT_W'(1);
                            w_state_nxt = S_RELEASE_WAIT;
                        end
                    end
                end
                S_RELEASE_WAIT: begin
                    if (!w_empty) begin
                        w_state_nxt = S_HELD;
                    end else if (w_cnt_inc >= DEB_TGT) begin
                        w_release   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Accepted code is always this frame's single hit, so w_first is used directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cand      <= 4'd0;
            r_cnt       <= '0;
            key_code    <= 4'd0;
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
            pattern_idx <= 4'd0;
            draw        <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cand    <= w_cand_nxt;
            r_cnt     <= w_cnt_nxt;
            key_valid <= w_accept;
            draw      <= w_accept && (w_first == 4'd15);
            if (w_accept) begin
                key_code <= w_first;
                key_held <= 1'b1;
                if (w_first <= 4'd9) begin
                    pattern_idx <= w_first;
                end
            end else if (w_release) begin
                key_held <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Directed bench for keypad_scanner with an expected-event queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] keypadCol;
    logic [3:0] keypadRow;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [3:0] pattern_idx;
    logic       draw;

    logic [15:0] keys;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [3:0]  exp_pidx = 4'd0;
    logic        prev_valid = 1'b0;

    typedef struct {
        logic [3:0] code;
        logic [3:0] pidx;
        logic       drw;
        int         at;
    } ev_t;
    ev_t q[$];

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .keypadCol  (keypadCol),
        .keypadRow  (keypadRow),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_held   (key_held),
        .pattern_idx(pattern_idx),
        .draw       (draw)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive key matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        keypadCol = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !keypadRow[r]) keypadCol[c] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input logic [3:0] code, input int at);
        ev_t e;
        if (code <= 4'd9) exp_pidx = code;
        e.code = code;
        e.pidx = exp_pidx;
        e.drw  = (code == 4'd15);
        e.at   = at;
        q.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic sync_frame(output int fs);
        logic [3:0] prev;
        logic       found;
        found = 1'b0;
        fs    = cyc;
        for (int i = 0; i < 40 && !found; i++) begin
            prev = keypadRow;
            @(negedge clk);
            if (keypadRow == 4'b1110 && prev == 4'b0111) begin
                found = 1'b1;
                fs    = cyc;
            end
        end
        check("frame_sync", {31'd0, found}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (key_valid) begin
            check("valid_width", {31'd0, prev_valid}, 32'd0);
            if (q.size() == 0) begin
                check("unexpected_pulse", 32'(q.size()), 32'd1);
            end else begin
                ev_t e;
                e = q.pop_front();
                check("kv_code", {28'd0, key_code}, {28'd0, e.code});
                check("kv_pidx", {28'd0, pattern_idx}, {28'd0, e.pidx});
                check("kv_draw", {31'd0, draw}, {31'd0, e.drw});
                check("kv_held", {31'd0, key_held}, 32'd1);
                check("kv_cycle", cyc, e.at);
            end
        end
        if (draw && !key_valid) check("draw_alone", {31'd0, draw}, 32'd0);
        prev_valid <= key_valid;
    end

    initial begin
        int f;
        int r;
        logic [3:0] exp_row;

        // Reset state
        rst  = 1'b0;
        keys = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_row", {28'd0, keypadRow}, 32'b1110);
        check("rst_code", {28'd0, key_code}, 32'd0);
        check("rst_valid", {31'd0, key_valid}, 32'd0);
        check("rst_held", {31'd0, key_held}, 32'd0);
        check("rst_pidx", {28'd0, pattern_idx}, 32'd0);
        check("rst_draw", {31'd0, draw}, 32'd0);

        // Row sequence: 4 cycles per row starting from reset release
        rst = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            if (n % 4 == 2) begin
                exp_row = 4'b0001 << ((n / 4) % 4);
                exp_row = ~exp_row;
                check("row_seq", {28'd0, keypadRow}, {28'd0, exp_row});
            end
        end

        // Hold code 6 from a frame start, then 10 more frames
        sync_frame(f);
        keys = 16'h0040;
        push_ev(4'd6, f + 48);
        wait_until(f + 49);
        check("c6_held", {31'd0, key_held}, 32'd1);
        check("c6_code", {28'd0, key_code}, 32'd6);
        check("c6_pidx", {28'd0, pattern_idx}, 32'd6);
        check("c6_draw", {31'd0, draw}, 32'd0);
        wait_until(f + 48 + 160);
        check("c6_still_held", {31'd0, key_held}, 32'd1);

        // Release: held drops after three empty frames
        sync_frame(f);
        keys = 16'h0000;
        wait_until(f + 47);
        check("rel_held_before", {31'd0, key_held}, 32'd1);
        wait_until(f + 48);
        check("rel_held_after", {31'd0, key_held}, 32'd0);

        // Re-press within release window: no new event, held stays high
        sync_frame(f);
        keys = 16'h0040;
        push_ev(4'd6, f + 48);
        wait_until(f + 64);
        keys = 16'h0000;
        wait_until(f + 80);
        keys = 16'h0040;
        wait_until(f + 112);
        check("repress_held_a", {31'd0, key_held}, 32'd1);
        wait_until(f + 128);
        check("repress_held_b", {31'd0, key_held}, 32'd1);
        keys = 16'h0000;
        wait_until(f + 176);
        check("repress_released", {31'd0, key_held}, 32'd0);

        // Code 15 drives draw; pattern_idx keeps 6
        sync_frame(f);
        keys = 16'h8000;
        push_ev(4'd15, f + 48);
        wait_until(f + 48);
        keys = 16'h0000;
        wait_until(f + 49);
        check("c15_code", {28'd0, key_code}, 32'd15);
        check("c15_pidx", {28'd0, pattern_idx}, 32'd6);
        check("c15_draw_done", {31'd0, draw}, 32'd0);
        wait_until(f + 96);
        check("c15_released", {31'd0, key_held}, 32'd0);

        // Bounce: 2 present, 1 absent, 3 present
        sync_frame(f);
        keys = 16'h0004;
        wait_until(f + 32);
        keys = 16'h0000;
        wait_until(f + 48);
        keys = 16'h0004;
        push_ev(4'd2, f + 96);
        wait_until(f + 96);
        keys = 16'h0000;
        wait_until(f + 144);
        check("bounce_released", {31'd0, key_held}, 32'd0);
        check("bounce_pidx", {28'd0, pattern_idx}, 32'd2);

        // Two keys together are never accepted
        sync_frame(f);
        keys = 16'h0204;
        wait_until(f + 80);
        keys = 16'h0000;
        check("multi_held", {31'd0, key_held}, 32'd0);
        check("multi_code", {28'd0, key_code}, 32'd2);

        // Candidate switch from 2 to 5
        sync_frame(f);
        keys = 16'h0004;
        wait_until(f + 32);
        keys = 16'h0020;
        push_ev(4'd5, f + 80);
        wait_until(f + 80);
        keys = 16'h0000;
        wait_until(f + 128);
        check("switch_released", {31'd0, key_held}, 32'd0);
        check("switch_pidx", {28'd0, pattern_idx}, 32'd5);

        // Asynchronous reset in the second frame of a code-4 press
        sync_frame(f);
        keys = 16'h0010;
        wait_until(f + 20);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_row", {28'd0, keypadRow}, 32'b1110);
        check("mid_rst_held", {31'd0, key_held}, 32'd0);
        check("mid_rst_valid", {31'd0, key_valid}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        r = cyc;
        push_ev(4'd4, r + 48);
        wait_until(r + 47);
        check("post_rst_not_yet", {31'd0, key_held}, 32'd0);
        wait_until(r + 49);
        check("post_rst_held", {31'd0, key_held}, 32'd1);
        check("post_rst_code", {28'd0, key_code}, 32'd4);
        keys = 16'h0000;
        wait_until(r + 100);

        check("pending_events", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
